// File: rtl/crtc_bus_arbiter.sv
// Main-RAM bus arbiter between the Z80 CPU and the CRTC row-buffer DMA.
// Optional statistics registers are built when CRTC_ARB_STATS_EN is defined.
module crtc_bus_arbiter #(
    parameter int ADR_W    = 17,
    parameter int MAX_WAIT = 64,
    parameter int MIN_GAP  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dma_req,
    output logic             dma_ack,
    input  logic [ADR_W-1:0] dma_adr,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic             cpu_mreq_n,
    input  logic             cpu_wr_n,
    output logic             cpu_busrq_n,
    input  logic             cpu_busak_n,
    output logic [ADR_W-1:0] ram_adr,
    output logic             ram_we,
    input  logic             late_clr,
    output logic             late,
    output logic             dma_busy,
    output logic [15:0]      stat_grants,
    output logic [7:0]       stat_maxwait
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [7:0] MIN_GAP_C  = 8'(MIN_GAP);

    state_t     state_r;
    state_t     next_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] gap_cnt_r;
    logic [7:0] wait_inc_s;
    logic       late_set_s;
    logic       busrq_n_r;
    logic       ack_r;
    logic       busy_r;
    logic       late_r;

    assign wait_inc_s = (wait_cnt_r == 8'hFF) ? 8'hFF : (wait_cnt_r + 8'd1);
    assign late_set_s = (state_r == ST_ASSERT) && (wait_inc_s == MAX_WAIT_C);

    // Next-state decode for the bus handshake.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dma_req) next_s = ST_ASSERT;
                else         next_s = ST_IDLE;
            end
            ST_ASSERT: begin
                if (!cpu_busak_n)  next_s = ST_GRANT;
                else if (!dma_req) next_s = ST_RELEASE;
                else               next_s = ST_ASSERT;
            end
            ST_GRANT: begin
                if (!dma_req) next_s = ST_RELEASE;
                else          next_s = ST_GRANT;
            end
            ST_RELEASE: begin
                if (cpu_busak_n) next_s = (MIN_GAP_C == 8'd0) ? ST_IDLE : ST_GAP;
                else             next_s = ST_RELEASE;
            end
            ST_GAP: begin
                if (gap_cnt_r <= 8'd1) next_s = ST_IDLE;
                else                   next_s = ST_GAP;
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // State, registered handshake outputs and wait/gap counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            busrq_n_r  <= 1'b1;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            wait_cnt_r <= 8'd0;
            gap_cnt_r  <= 8'd0;
        end else begin
            state_r   <= next_s;
            busrq_n_r <= !((next_s == ST_ASSERT) || (next_s == ST_GRANT));
            ack_r     <= (next_s == ST_GRANT);
            busy_r    <= (next_s != ST_IDLE);
            if (state_r == ST_IDLE && next_s == ST_ASSERT) wait_cnt_r <= 8'd0;
            else if (state_r == ST_ASSERT)                 wait_cnt_r <= wait_inc_s;
            else                                           wait_cnt_r <= wait_cnt_r;
            if (state_r == ST_RELEASE && next_s == ST_GAP)       gap_cnt_r <= MIN_GAP_C;
            else if (state_r == ST_GAP && gap_cnt_r != 8'd0)     gap_cnt_r <= gap_cnt_r - 8'd1;
            else                                                 gap_cnt_r <= gap_cnt_r;
        end
    end

    // Sticky late flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          late_r <= 1'b0;
        else if (late_set_s) late_r <= 1'b1;
        else if (late_clr)   late_r <= 1'b0;
        else                 late_r <= late_r;
    end

`ifdef CRTC_ARB_STATS_EN
    logic [15:0] grants_r;
    logic [7:0]  maxwait_r;

    // Burst count and worst-case grant latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_r  <= 16'd0;
            maxwait_r <= 8'd0;
        end else begin
            if (state_r == ST_GRANT && next_s == ST_RELEASE) grants_r <= grants_r + 16'd1;
            else                                             grants_r <= grants_r;
            if (state_r == ST_ASSERT && next_s == ST_GRANT && wait_inc_s > maxwait_r)
                maxwait_r <= wait_inc_s;
            else
                maxwait_r <= maxwait_r;
        end
    end

    assign stat_grants  = grants_r;
    assign stat_maxwait = maxwait_r;
`else
    assign stat_grants  = 16'd0;
    assign stat_maxwait = 8'd0;
`endif

    assign dma_ack     = ack_r;
    assign cpu_busrq_n = busrq_n_r;
    assign dma_busy    = busy_r;
    assign late        = late_r;
    // CPU strobes are masked while the DMA owns the bus.
    assign ram_adr     = (state_r == ST_GRANT) ? dma_adr : cpu_adr;
    assign ram_we      = !cpu_mreq_n && !cpu_wr_n && (state_r != ST_GRANT);

endmodule

// File: tb/tb_crtc_bus_arbiter.sv
// Self-checking bench for crtc_bus_arbiter: directed scenarios, then random
// traffic against a behavioural model of the bus-ownership rules.
module tb_crtc_bus_arbiter;

    localparam int ADR_W    = 17;
    localparam int MAX_WAIT = 64;
    localparam int MIN_GAP  = 8;

    localparam int P_IDLE = 0, P_ASSERT = 1, P_GRANT = 2, P_RELEASE = 3, P_GAP = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             dma_req = 1'b0;
    logic             dma_ack;
    logic [ADR_W-1:0] dma_adr = '0;
    logic [ADR_W-1:0] cpu_adr = '0;
    logic             cpu_mreq_n = 1'b1;
    logic             cpu_wr_n = 1'b1;
    logic             cpu_busrq_n;
    logic             cpu_busak_n = 1'b1;
    logic [ADR_W-1:0] ram_adr;
    logic             ram_we;
    logic             late_clr = 1'b0;
    logic             late;
    logic             dma_busy;
    logic [15:0]      stat_grants;
    logic [7:0]       stat_maxwait;

    int checks = 0;
    int failures = 0;

    crtc_bus_arbiter #(.ADR_W(ADR_W), .MAX_WAIT(MAX_WAIT), .MIN_GAP(MIN_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .dma_req(dma_req), .dma_ack(dma_ack),
        .dma_adr(dma_adr), .cpu_adr(cpu_adr), .cpu_mreq_n(cpu_mreq_n),
        .cpu_wr_n(cpu_wr_n), .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
        .ram_adr(ram_adr), .ram_we(ram_we), .late_clr(late_clr), .late(late),
        .dma_busy(dma_busy), .stat_grants(stat_grants), .stat_maxwait(stat_maxwait)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the bus and the bookkeeping around it.
    int          m_ph;
    int          m_wait;
    int          m_gap;
    logic        m_late;
    logic [15:0] m_grants;
    int          m_maxwait;

    function automatic int sat_inc(input int w);
        return (w >= 255) ? 255 : w + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= P_IDLE; m_wait <= 0; m_gap <= 0; m_late <= 1'b0;
            m_grants <= 16'd0; m_maxwait <= 0;
        end else begin
            if (m_ph == P_ASSERT && sat_inc(m_wait) == MAX_WAIT) m_late <= 1'b1;
            else if (late_clr)                                  m_late <= 1'b0;
            case (m_ph)
                P_IDLE: if (dma_req) begin m_ph <= P_ASSERT; m_wait <= 0; end
                P_ASSERT: begin
                    m_wait <= sat_inc(m_wait);
                    if (!cpu_busak_n) begin
                        m_ph <= P_GRANT;
                        if (sat_inc(m_wait) > m_maxwait) m_maxwait <= sat_inc(m_wait);
                    end else if (!dma_req) m_ph <= P_RELEASE;
                end
                P_GRANT: if (!dma_req) begin m_ph <= P_RELEASE; m_grants <= m_grants + 16'd1; end
                P_RELEASE: if (cpu_busak_n) begin
                    if (MIN_GAP == 0) m_ph <= P_IDLE;
                    else begin m_ph <= P_GAP; m_gap <= MIN_GAP; end
                end
                P_GAP: begin
                    m_gap <= m_gap - 1;
                    if (m_gap <= 1) m_ph <= P_IDLE;
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Z80 responder and random-traffic state.
    bit rnd = 1'b0;
    int ack_delay = 1;
    int rel_delay = 0;
    int ack_cnt = 0;
    int rel_cnt = 0;

    task automatic tick();
        logic [ADR_W-1:0] e_adr;
        logic             e_we;
        @(negedge clk);
        if (rst_n) begin
            e_adr = (m_ph == P_GRANT) ? dma_adr : cpu_adr;
            e_we  = !cpu_mreq_n && !cpu_wr_n && (m_ph != P_GRANT);
            chk("dma_ack",     32'(dma_ack),     32'(m_ph == P_GRANT));
            chk("cpu_busrq_n", 32'(cpu_busrq_n), 32'(!(m_ph == P_ASSERT || m_ph == P_GRANT)));
            chk("dma_busy",    32'(dma_busy),    32'(m_ph != P_IDLE));
            chk("late",        32'(late),        32'(m_late));
            chk("ram_adr",     32'(ram_adr),     32'(e_adr));
            chk("ram_we",      32'(ram_we),      32'(e_we));
`ifdef CRTC_ARB_STATS_EN
            chk("stat_grants",  32'(stat_grants),  32'(m_grants));
            chk("stat_maxwait", 32'(stat_maxwait), 32'(m_maxwait));
`else
            chk("stat_grants",  32'(stat_grants),  32'd0);
            chk("stat_maxwait", 32'(stat_maxwait), 32'd0);
`endif
        end
        if (cpu_busrq_n == 1'b0) begin
            rel_cnt = 0;
            ack_cnt++;
            if (rnd && ack_cnt == 1) begin
                ack_delay = ($urandom_range(0, 15) == 0) ? 70 : $urandom_range(0, 4);
                rel_delay = $urandom_range(0, 3);
            end
            if (ack_cnt > ack_delay) cpu_busak_n = 1'b0;
        end else begin
            ack_cnt = 0;
            if (cpu_busak_n == 1'b0) begin
                rel_cnt++;
                if (rel_cnt > rel_delay) cpu_busak_n = 1'b1;
            end
        end
        late_clr = 1'b0;
        if (rnd) begin
            cpu_adr    = 17'($urandom);
            dma_adr    = 17'($urandom);
            cpu_mreq_n = 1'($urandom_range(0, 1));
            cpu_wr_n   = 1'($urandom_range(0, 1));
            late_clr   = ($urandom_range(0, 40) == 0);
            if (dma_req) begin
                if (m_ph == P_GRANT && $urandom_range(0, 7) == 0)       dma_req = 1'b0;
                else if (m_ph == P_ASSERT && $urandom_range(0, 29) == 0) dma_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                dma_req = 1'b1;
            end
        end
    endtask

    task automatic wait_ack(input int maxc, output int n);
        n = 0;
        while (dma_ack !== 1'b1 && n < maxc) begin tick(); n++; end
        if (dma_ack !== 1'b1) chk("timeout_ack", 32'(dma_ack), 32'd1);
    endtask

    task automatic wait_idle(input int maxc, output int n);
        n = 0;
        do begin tick(); n++; end while (dma_busy !== 1'b0 && n < maxc);
        if (dma_busy !== 1'b0) chk("timeout_idle", 32'(dma_busy), 32'd0);
    endtask

    task automatic burst();
        int n;
        dma_req = 1'b1;
        wait_ack(200, n);
        tick(); tick();
        dma_req = 1'b0;
        wait_idle(200, n);
    endtask

    initial begin
        int n;
        int hi;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_busrq_n", 32'(cpu_busrq_n), 32'd1);
        chk("rst_late", 32'(late), 32'd0);
        chk("rst_busy", 32'(dma_busy), 32'd0);

        // Nominal grant latency and address mux.
        ack_delay = 1; rel_delay = 0;
        dma_adr = 17'h0F300; cpu_adr = 17'h00100;
        dma_req = 1'b1;
        wait_ack(20, n);
        chk("t1_latency", 32'(n), 32'd3);
        chk("t1_ram_adr", 32'(ram_adr), 32'h0F300);
        cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
        #1 chk("t2_we_grant", 32'(ram_we), 32'd0);
        tick();
        cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;

        // Immediate re-request after the burst must sit out the gap.
        dma_req = 1'b0;
        tick();
        dma_req = 1'b1;
        hi = 0;
        n = 0;
        while (cpu_busrq_n !== 1'b0 && n < 50) begin
            if (cpu_busak_n === 1'b1) hi++;
            tick(); n++;
        end
        chk("t5_gap_ge_min", 32'(hi >= MIN_GAP), 32'd1);
        wait_ack(20, n);
        dma_req = 1'b0;
        wait_idle(50, n);
        cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
        #1 chk("t2_we_idle", 32'(ram_we), 32'd1);
        chk("t2_adr_idle", 32'(ram_adr), 32'h00100);
        tick();
        cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;

        // Withheld grant raises late; a clear pulse drops it.
        ack_delay = 70;
        dma_req = 1'b1;
        n = 0;
        while (late !== 1'b1 && n < 100) begin tick(); n++; end
        chk("t3_late_at", 32'(n), 32'd65);
        late_clr = 1'b1;
        tick();
        chk("t3_late_clr", 32'(late), 32'd0);
        wait_ack(20, n);
        dma_req = 1'b0;
        wait_idle(50, n);

        // Abort while waiting: no ack, gap of MIN_GAP clocks, back to idle.
        ack_delay = 100;
        dma_req = 1'b1;
        repeat (3) tick();
        dma_req = 1'b0;
        tick();
        chk("t4_busrq_rel", 32'(cpu_busrq_n), 32'd1);
        chk("t4_no_ack", 32'(dma_ack), 32'd0);
        wait_idle(50, n);
        chk("t4_idle_after", 32'(n + 1), 32'd10);

        // Reset mid-grant aborts immediately.
        ack_delay = 1;
        dma_req = 1'b1;
        wait_ack(20, n);
        rst_n = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("t6_rst_ack", 32'(dma_ack), 32'd0);
        chk("t6_rst_busrq", 32'(cpu_busrq_n), 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) burst();
`ifdef CRTC_ARB_STATS_EN
        chk("t6_grants3", 32'(stat_grants), 32'd3);
`else
        chk("t6_grants3", 32'(stat_grants), 32'd0);
`endif

        rnd = 1'b1;
        repeat (4000) tick();
        rnd = 1'b0;
        dma_req = 1'b0;
        repeat (100) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
